axi_script_parser: RTL



---
 rtl/axi_script_parser_pkg.sv | 50 +++++
 rtl/axi_script_parser_hex_field_acc.sv | 37 +++
 rtl/axi_script_parser.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_script_parser_pkg.sv
// Shared types and helpers for the script-line parser: error codes, FSM states,
// command opcode encoding and ASCII hex classification.
package parser_pkg;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] BAD_OP     = 3'd1;
    localparam logic [2:0] BAD_SYNTAX = 3'd2;
    localparam logic [2:0] OVERFLOW   = 3'd3;
    localparam logic [2:0] BAD_SIZE   = 3'd4;
    localparam logic [2:0] EARLY_EOL  = 3'd5;

    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_SP  = 8'h20;

    typedef enum logic [4:0] {
        LINE_START, KW, OP1, OP2, LPAR, A0, AX, AHEX, DSEP,
        D0, DX, DHEX, IDF, ISEP, SZ, RPAR, EMIT, TAIL, SKIP
    } state_e;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } cmd_op_e;

    function automatic logic is_hex(input logic [7:0] ch);
        return (ch >= 8'h30 && ch <= 8'h39) ||
               (ch >= 8'h41 && ch <= 8'h46) ||
               (ch >= 8'h61 && ch <= 8'h66);
    endfunction

    // Letters in both cases have low nibble 1..6, so +9 maps them to 10..15.
    function automatic logic [3:0] hex_nibble(input logic [7:0] ch);
        if (ch <= 8'h39)
            return ch[3:0];
        else
            return ch[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] kw_char(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h58; // X
            2'd1:    return 8'h49; // I
            2'd2:    return 8'h34; // 4
            default: return 8'h5F; // _
        endcase
    endfunction

endpackage

// File: rtl/axi_script_parser_hex_field_acc.sv
// Hex field accumulator: shifts in one nibble per push and tracks the digit count
// so the caller can reject a digit that would exceed MAX_DIGITS.
module hex_field_acc #(
    parameter int MAX_DIGITS = 16,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic [3:0]              i_nibble,
    output logic [MAX_DIGITS*4-1:0] o_value,
    output logic [CW-1:0]           o_count,
    output logic                    o_full
);

    logic [MAX_DIGITS*4-1:0] r_value;
    logic [CW-1:0]           r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_value <= {r_value[MAX_DIGITS*4-5:0], i_nibble};
            r_count <= r_count + CW'(1);
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(MAX_DIGITS));

endmodule

// File: rtl/axi_script_parser.sv
// Replays logger script lines: parses AXI4_WR/RD(0x<addr>,0x<data>,0,<size>) from a
// character stream into command records, with error reporting and line statistics.
module axi_script_parser
    import parser_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic [2:0]        cmd_size,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  line_cnt,
    output logic [CNT_W-1:0]  cmd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int A_DIG    = ADDR_W / 4;
    localparam int D_DIG    = DATA_W / 4;
    localparam int A_CW     = $clog2(A_DIG + 1);
    localparam int D_CW     = $clog2(D_DIG + 1);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    state_e          r_state, w_next;
    logic [1:0]      r_kw_idx, w_kw_next;
    cmd_op_e         r_op, w_op_val;
    logic            w_op_set;
    logic [2:0]      r_size;
    logic            w_size_set;
    logic            r_err_valid;
    logic [2:0]      r_err_code, w_err_code;
    logic            w_err;
    logic [CNT_W-1:0] r_line_cnt, r_cmd_cnt, r_err_cnt;

    logic            w_fire, w_is_lf, w_is_hex, w_line_inc, w_cmd_done;
    logic [3:0]      w_nibble;
    logic            w_acc_clear, w_addr_push, w_data_push;
    logic [ADDR_W-1:0] w_addr_val;
    logic [DATA_W-1:0] w_data_val;
    logic [A_CW-1:0] w_addr_cnt;
    logic [D_CW-1:0] w_data_cnt;
    logic            w_addr_full, w_data_full;

    function automatic logic in_cmd(input state_e s);
        return s inside {OP1, OP2, LPAR, A0, AX, AHEX, DSEP, D0, DX, DHEX, IDF, ISEP, SZ, RPAR};
    endfunction

    assign w_fire      = char_valid && char_ready;
    assign w_is_lf     = (char_data == CH_LF);
    assign w_is_hex    = is_hex(char_data);
    assign w_nibble    = hex_nibble(char_data);
    assign w_acc_clear = (r_state == LINE_START);

    hex_field_acc #(.MAX_DIGITS(A_DIG), .CW(A_CW)) u_addr_acc (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_acc_clear),
        .i_push   (w_addr_push),
        .i_nibble (w_nibble),
        .o_value  (w_addr_val),
        .o_count  (w_addr_cnt),
        .o_full   (w_addr_full)
    );

    hex_field_acc #(.MAX_DIGITS(D_DIG), .CW(D_CW)) u_data_acc (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_acc_clear),
        .i_push   (w_data_push),
        .i_nibble (w_nibble),
        .o_value  (w_data_val),
        .o_count  (w_data_cnt),
        .o_full   (w_data_full)
    );

    always_comb begin
        w_next      = r_state;
        w_kw_next   = r_kw_idx;
        w_op_set    = 1'b0;
        w_op_val    = r_op;
        w_size_set  = 1'b0;
        w_addr_push = 1'b0;
        w_data_push = 1'b0;
        w_line_inc  = 1'b0;
        w_cmd_done  = 1'b0;
        w_err_code  = ERR_NONE;

        if (r_state == EMIT) begin
            if (cmd_ready) begin
                w_cmd_done = 1'b1;
                w_next     = TAIL;
            end
        end else if (w_fire) begin
            // Early end-of-line returns straight to LINE_START; other errors drain via SKIP.
            if (w_is_lf && in_cmd(r_state)) begin
                w_err_code = EARLY_EOL;
                w_line_inc = 1'b1;
                w_next     = LINE_START;
            end else begin
                case (r_state)
                    LINE_START: begin
                        w_kw_next = '0;
                        if (w_is_lf)
                            w_line_inc = 1'b1;
                        else if (char_data == 8'h41)
                            w_next = KW;
                        else if (!(char_data == CH_SP || char_data == CH_TAB || char_data == CH_CR))
                            w_next = SKIP;
                    end
                    KW: begin
                        if (char_data == kw_char(r_kw_idx)) begin
                            w_kw_next = r_kw_idx + 2'd1;
                            if (r_kw_idx == 2'd3)
                                w_next = OP1;
                        end else if (w_is_lf) begin
                            w_line_inc = 1'b1;
                            w_next     = LINE_START;
                        end else begin
                            w_next = SKIP;
                        end
                    end
                    OP1: begin
                        if (char_data == 8'h57) begin
                            w_op_set = 1'b1;
                            w_op_val = OP_WR;
                            w_next   = OP2;
                        end else if (char_data == 8'h52) begin
                            w_op_set = 1'b1;
                            w_op_val = OP_RD;
                            w_next   = OP2;
                        end else begin
                            w_err_code = BAD_OP;
                        end
                    end
                    OP2: begin
                        if ((r_op == OP_WR && char_data == 8'h52) ||
                            (r_op == OP_RD && char_data == 8'h44))
                            w_next = LPAR;
                        else
                            w_err_code = BAD_OP;
                    end
                    LPAR: if (char_data == 8'h28) w_next = A0;   else w_err_code = BAD_SYNTAX;
                    A0:   if (char_data == 8'h30) w_next = AX;   else w_err_code = BAD_SYNTAX;
                    AX:   if (char_data == 8'h78) w_next = AHEX; else w_err_code = BAD_SYNTAX;
                    AHEX: begin
                        if (w_is_hex) begin
                            if (w_addr_full) w_err_code = OVERFLOW;
                            else             w_addr_push = 1'b1;
                        end else if (char_data == 8'h2C && w_addr_cnt != '0) begin
                            w_next = D0;
                        end else begin
                            w_err_code = BAD_SYNTAX;
                        end
                    end
                    D0:   if (char_data == 8'h30) w_next = DX;   else w_err_code = BAD_SYNTAX;
                    DX:   if (char_data == 8'h78) w_next = DHEX; else w_err_code = BAD_SYNTAX;
                    DHEX: begin
                        if (w_is_hex) begin
                            if (w_data_full) w_err_code = OVERFLOW;
                            else             w_data_push = 1'b1;
                        end else if (char_data == 8'h2C && w_data_cnt != '0) begin
                            w_next = IDF;
                        end else begin
                            w_err_code = BAD_SYNTAX;
                        end
                    end
                    IDF:  if (char_data == 8'h30) w_next = ISEP; else w_err_code = BAD_SYNTAX;
                    ISEP: if (char_data == 8'h2C) w_next = SZ;   else w_err_code = BAD_SYNTAX;
                    SZ: begin
                        if (char_data >= 8'h32 && char_data <= 8'h35 &&
                            int'(char_data[2:0]) <= MAX_SIZE) begin
                            w_size_set = 1'b1;
                            w_next     = RPAR;
                        end else begin
                            w_err_code = BAD_SIZE;
                        end
                    end
                    RPAR: if (char_data == 8'h29) w_next = EMIT; else w_err_code = BAD_SYNTAX;
                    TAIL, SKIP: begin
                        if (w_is_lf) begin
                            w_line_inc = 1'b1;
                            w_next     = LINE_START;
                        end
                    end
                    default: w_next = r_state;
                endcase
                if (w_err_code != ERR_NONE)
                    w_next = SKIP;
            end
        end
    end

    assign w_err = (w_err_code != ERR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LINE_START;
            r_kw_idx    <= '0;
            r_op        <= OP_WR;
            r_size      <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_line_cnt  <= '0;
            r_cmd_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_next;
            r_kw_idx    <= w_kw_next;
            r_err_valid <= w_err;
            if (w_op_set)   r_op       <= w_op_val;
            if (w_size_set) r_size     <= char_data[2:0];
            if (w_err) begin
                r_err_code <= w_err_code;
                r_err_cnt  <= r_err_cnt + CNT_W'(1);
            end
            if (w_line_inc) r_line_cnt <= r_line_cnt + CNT_W'(1);
            if (w_cmd_done) r_cmd_cnt  <= r_cmd_cnt + CNT_W'(1);
        end
    end

    assign char_ready = (r_state != EMIT);
    assign cmd_valid  = (r_state == EMIT);
    assign cmd_op     = r_op;
    assign cmd_addr   = w_addr_val;
    assign cmd_data   = w_data_val;
    assign cmd_size   = r_size;
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign line_cnt   = r_line_cnt;
    assign cmd_cnt    = r_cmd_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
